period_to_note: RTL and testbench
=================================

PERIOD_TO_NOTE -- requirements
Module: period_to_note

Interface
REQ-001 Parameter CLK_HZ, default 12_000_000, system clock frequency in Hz; tables in tuner_pkg are generated for this value.
REQ-002 Parameter PERIOD_W, default 20, width of the period counter in bits.
REQ-003 Parameter TIMEOUT_CYC, default 600_000, number of cycles without an edge before "no signal" is declared.
REQ-004 Parameter MIN_PERIOD, default 1_000, minimum accepted period in cycles; edges that arrive sooner are treated as glitches.
REQ-005 Port clk_i, input, 1 bit: the single clock; every register is clocked on its rising edge.
REQ-006 Port reset_i, input, 1 bit: synchronous, active-high reset.
REQ-007 Port edge_i, input, 1 bit: one-cycle pulse per rising zero-crossing, already synchronised to clk_i.
REQ-008 Port note_o, output, 4 bits: semitone code. 0x0=A, 0x1=Bb, 0x2=B, 0x3=C, 0x4=C#, 0x5=D, 0x6=Eb, 0x7=E, 0x8=F, 0x9=F#, 0xA=G, 0xB=G#; 0xF=no signal.
REQ-009 Port flat_o, output, 1 bit: the measured pitch is below the note centre by more than the tolerance.
REQ-010 Port sharp_o, output, 1 bit: the measured pitch is above the note centre by more than the tolerance.
REQ-011 Port valid_o, output, 1 bit: one-cycle pulse issued whenever note_o, flat_o or sharp_o is updated.

Function
REQ-012 Period counting: the counter increments every cycle, saturates at all-ones, and restarts at 1 on each accepted edge.
REQ-013 The first edge after reset or after a timeout only starts counting; it produces no classification.
REQ-014 Edge acceptance: an edge with count < MIN_PERIOD is ignored, and the counter does not restart.
REQ-015 Edge capture: an accepted edge with count >= MIN_PERIOD captures count as P and moves the FSM IDLE->NORM.
REQ-016 FSM states are IDLE, NORM, CLASS and DONE; the FSM returns from DONE to IDLE after one cycle.
REQ-017 NORM performs one shift per cycle: if P > B_HI, P is shifted right by 1; else if P <= B_HI>>1, P is shifted left by 1; otherwise the FSM goes to CLASS.
REQ-018 Constants: B_HI = CLK_HZ/(440*2^(-1/24)), i.e. a quarter-tone below A; CTR_k = CLK_HZ/(440*2^(k/12)) for k = 0..11.
REQ-019 CLASS compares P against the 11 quarter-tone boundaries BND_k (between CTR_k and CTR_k+1), one comparison per cycle, starting at k=0.
REQ-020 CLASS selects the first k with P > BND_k; if there is none, k = 11.
REQ-021 Tolerance: TOL = CTR_k >> 7 (about 13.5 cents); flat = P > CTR_k + TOL; sharp = P < CTR_k - TOL; flat and sharp are never both 1.
REQ-022 DONE registers note_o = k together with flat_o and sharp_o, and pulses valid_o for exactly one cycle.
REQ-023 Latency from a captured edge to valid_o is at most PERIOD_W + 14 cycles.
REQ-024 An accepted edge arriving while the FSM is not IDLE restarts the counter but is not captured.
REQ-025 Timeout: when count reaches TIMEOUT_CYC, the block sets note_o = 0xF, flat_o = 0 and sharp_o = 0, and pulses valid_o once.
REQ-026 After a timeout, valid_o does not pulse again until a new classification completes.
REQ-027 If a timeout and a captured edge occur in the same cycle, the edge wins.
REQ-028 Arithmetic is unsigned throughout; a left shift never overflows, because P is below B_HI at that point.

Reset
REQ-029 On reset_i=1 at a clock edge: FSM = IDLE, counter = 0, note_o = 0xF, flat_o = 0, sharp_o = 0, valid_o = 0, first-edge flag set.
REQ-030 Reset asserted mid-classification abandons the classification with no valid_o pulse.

Configuration
REQ-031 Macro PERIOD_AVG_EN defined: four consecutive captured periods are summed and shifted right by 2 before NORM.
REQ-032 With PERIOD_AVG_EN, the first result after reset or timeout needs five edges, and a timeout clears the accumulator.
REQ-033 Macro PERIOD_AVG_EN undefined: every captured period is classified individually.

Structure
REQ-034 tuner_pkg holds the note-code constants (including the no-signal code 0xF), the FSM state enum, and the B_HI/CTR/BND tables computed from CLK_HZ.
REQ-035 Sub-module period_counter provides the saturating counter, MIN_PERIOD glitch filter, first-edge flag and timeout; period_to_note instantiates it.

Verification (CLK_HZ = 12 MHz)
REQ-036 Edges every 27273 cycles (440 Hz) -> after the second edge, note_o=0x0, flat_o=0, sharp_o=0, valid_o pulses once per period.
REQ-037 Edges every 54545 cycles (220 Hz) -> one right shift in NORM; note_o=0x0, in tune.
REQ-038 Edges every 45867 cycles (C4, 261.63 Hz) -> note_o=0x3, flat_o=0, sharp_o=0.
REQ-039 Edges every 26667 cycles (450 Hz) -> note_o=0x0, sharp_o=1, flat_o=0.
REQ-040 A 440 Hz tone, then no edges for 600000 cycles -> note_o=0xF with one valid_o pulse; an extra edge 500 cycles after an accepted edge is ignored.
REQ-041 Reset asserted during NORM -> no valid_o pulse, note_o=0xF; the next two 440 Hz edges give note_o=0x0.

Source files
------------

// File: rtl/tuner_pkg.sv
// Shared constants, FSM state type and period tables for the period-to-note tuner.
package tuner_pkg;

  localparam int unsigned NOTE_W      = 4;
  localparam int unsigned NUM_NOTES   = 12;
  localparam int unsigned NUM_BND     = 11;
  localparam int unsigned TAB_N       = 16;
  localparam int unsigned RATIO_SCALE = 1_000_000;
  localparam int unsigned A4_HZ       = 440;

  localparam logic [NOTE_W-1:0] NOTE_A    = 4'h0;
  localparam logic [NOTE_W-1:0] NOTE_BB   = 4'h1;
  localparam logic [NOTE_W-1:0] NOTE_B    = 4'h2;
  localparam logic [NOTE_W-1:0] NOTE_C    = 4'h3;
  localparam logic [NOTE_W-1:0] NOTE_CS   = 4'h4;
  localparam logic [NOTE_W-1:0] NOTE_D    = 4'h5;
  localparam logic [NOTE_W-1:0] NOTE_EB   = 4'h6;
  localparam logic [NOTE_W-1:0] NOTE_E    = 4'h7;
  localparam logic [NOTE_W-1:0] NOTE_F    = 4'h8;
  localparam logic [NOTE_W-1:0] NOTE_FS   = 4'h9;
  localparam logic [NOTE_W-1:0] NOTE_G    = 4'hA;
  localparam logic [NOTE_W-1:0] NOTE_GS   = 4'hB;
  localparam logic [NOTE_W-1:0] NOTE_NONE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_CLASS = 2'd2,
    ST_DONE  = 2'd3
  } fsm_state_e;

  // 2^(k/12) scaled by RATIO_SCALE, semitone k above A
  function automatic longint unsigned semi_ratio(input int unsigned k);
    case (k)
      0:       return 64'd1000000;
      1:       return 64'd1059463;
      2:       return 64'd1122462;
      3:       return 64'd1189207;
      4:       return 64'd1259921;
      5:       return 64'd1334840;
      6:       return 64'd1414214;
      7:       return 64'd1498307;
      8:       return 64'd1587401;
      9:       return 64'd1681793;
      10:      return 64'd1781797;
      11:      return 64'd1887749;
      default: return 64'd0;
    endcase
  endfunction

  // 2^((2j-1)/24) scaled by RATIO_SCALE: j=0 is a quarter-tone below A, j>=1 sits between semitones j-1 and j
  function automatic longint unsigned quarter_ratio(input int unsigned j);
    case (j)
      0:       return 64'd971532;
      1:       return 64'd1029302;
      2:       return 64'd1090508;
      3:       return 64'd1155353;
      4:       return 64'd1224054;
      5:       return 64'd1296840;
      6:       return 64'd1373954;
      7:       return 64'd1455653;
      8:       return 64'd1542211;
      9:       return 64'd1633915;
      10:      return 64'd1731073;
      11:      return 64'd1834008;
      default: return 64'd0;
    endcase
  endfunction

  // Period in clock cycles of 440 Hz scaled up by ratio; zero ratio yields zero
  function automatic longint unsigned period_for(input longint unsigned clk_hz,
                                                 input longint unsigned ratio);
    if (ratio == 64'd0) return 64'd0;
    return (clk_hz * 64'(RATIO_SCALE)) / (64'(A4_HZ) * ratio);
  endfunction

  // Centre period of semitone k, zero outside the octave
  function automatic longint unsigned ctr_cyc(input longint unsigned clk_hz, input int unsigned k);
    if (k >= NUM_NOTES) return 64'd0;
    return period_for(clk_hz, semi_ratio(k));
  endfunction

  // Boundary between semitone k and k+1, zero past the last boundary
  function automatic longint unsigned bnd_cyc(input longint unsigned clk_hz, input int unsigned k);
    if (k >= NUM_BND) return 64'd0;
    return period_for(clk_hz, quarter_ratio(k + 1));
  endfunction

  // Upper edge of the normalisation window: a quarter-tone below A
  function automatic longint unsigned b_hi_cyc(input longint unsigned clk_hz);
    return period_for(clk_hz, quarter_ratio(0));
  endfunction

endpackage

// File: rtl/period_counter.sv
// Saturating period counter with glitch filter, first-edge tracking and no-signal timeout.
module period_counter
  import tuner_pkg::*;
#(
  parameter int unsigned PERIOD_W    = 20,
  parameter int unsigned TIMEOUT_CYC = 600_000,
  parameter int unsigned MIN_PERIOD  = 1_000
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                edge_i,
  output logic [PERIOD_W-1:0] period_c,
  output logic                period_valid_c,
  output logic                timeout_c
);

  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

  logic [PERIOD_W-1:0] count_q, count_d;
  logic                first_q, first_d;
  logic                accept_c;

  // Edge qualification, timeout detection and next counter / first-edge values
  always_comb begin
    accept_c       = edge_i && (count_q >= PERIOD_W'(MIN_PERIOD));
    period_valid_c = accept_c && !first_q;
    // an accepted edge in the same cycle takes precedence over the timeout
    timeout_c      = (count_q == PERIOD_W'(TIMEOUT_CYC)) && !accept_c;
    period_c       = count_q;
    count_d        = count_q;
    first_d        = first_q;
    if (accept_c) begin
      count_d = PERIOD_W'(1);
    end else if (count_q != CNT_MAX) begin
      count_d = count_q + PERIOD_W'(1);
    end
    if (accept_c) begin
      first_d = 1'b0;
    end else if (timeout_c) begin
      first_d = 1'b1;
    end
  end

  // Counter and first-edge flag registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
      first_q <= 1'b1;
    end else begin
      count_q <= count_d;
      first_q <= first_d;
    end
  end

endmodule

// File: rtl/period_to_note.sv
// Classifies the period between zero-crossing edges into a semitone with flat/sharp flags.
// Optional macro PERIOD_AVG_EN: average four captured periods before classification.
module period_to_note
  import tuner_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 12_000_000,
  parameter int unsigned PERIOD_W    = 20,
  parameter int unsigned TIMEOUT_CYC = 600_000,
  parameter int unsigned MIN_PERIOD  = 1_000
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              edge_i,
  output logic [NOTE_W-1:0] note_o,
  output logic              flat_o,
  output logic              sharp_o,
  output logic              valid_o
);

  localparam int unsigned K_W = 4;
  localparam logic [PERIOD_W-1:0] B_HI      = PERIOD_W'(b_hi_cyc(64'(CLK_HZ)));
  localparam logic [PERIOD_W-1:0] B_HI_HALF = B_HI >> 1;
  localparam logic [K_W-1:0]      K_LAST_BND = K_W'(NUM_BND - 1);
  localparam logic [K_W-1:0]      K_TOP      = K_W'(NUM_NOTES - 1);

  logic [PERIOD_W-1:0] period_c;
  logic                period_valid_c;
  logic                timeout_c;

  logic [PERIOD_W-1:0] ctr_tab [TAB_N];
  logic [PERIOD_W-1:0] bnd_tab [TAB_N];

  fsm_state_e          state_q, state_d;
  logic [PERIOD_W-1:0] p_q, p_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic                flat_q, flat_d;
  logic                sharp_q, sharp_d;
  logic                valid_q, valid_d;

  logic                load_c;
  logic [PERIOD_W-1:0] load_p_c;

  logic [PERIOD_W-1:0] ctr_sel_c;
  logic [PERIOD_W-1:0] tol_c;
  logic [PERIOD_W:0]   hi_lim_c;
  logic [PERIOD_W-1:0] lo_lim_c;

  period_counter #(
    .PERIOD_W    (PERIOD_W),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .MIN_PERIOD  (MIN_PERIOD)
  ) u_counter (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .edge_i         (edge_i),
    .period_c       (period_c),
    .period_valid_c (period_valid_c),
    .timeout_c      (timeout_c)
  );

  // Constant centre and boundary tables derived from CLK_HZ
  for (genvar g = 0; g < TAB_N; g++) begin : g_tab
    assign ctr_tab[g] = PERIOD_W'(ctr_cyc(64'(CLK_HZ), 32'(g)));
    assign bnd_tab[g] = PERIOD_W'(bnd_cyc(64'(CLK_HZ), 32'(g)));
  end

`ifdef PERIOD_AVG_EN
  localparam int unsigned ACC_W = PERIOD_W + 2;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] acc_sum_c;
  logic [1:0]       avg_cnt_q, avg_cnt_d;

  // Accumulate four periods, release their mean on the fourth
  always_comb begin
    acc_d     = acc_q;
    avg_cnt_d = avg_cnt_q;
    load_c    = 1'b0;
    acc_sum_c = acc_q + ACC_W'(period_c);
    load_p_c  = PERIOD_W'(acc_sum_c >> 2);
    if (period_valid_c && (state_q == ST_IDLE)) begin
      if (avg_cnt_q == 2'd3) begin
        load_c    = 1'b1;
        acc_d     = '0;
        avg_cnt_d = '0;
      end else begin
        acc_d     = acc_sum_c;
        avg_cnt_d = avg_cnt_q + 2'd1;
      end
    end else if (timeout_c) begin
      acc_d     = '0;
      avg_cnt_d = '0;
    end
  end

  // Accumulator registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q     <= '0;
      avg_cnt_q <= '0;
    end else begin
      acc_q     <= acc_d;
      avg_cnt_q <= avg_cnt_d;
    end
  end
`else
  // Every captured period goes straight to normalisation
  always_comb begin
    load_c   = period_valid_c && (state_q == ST_IDLE);
    load_p_c = period_c;
  end
`endif

  // Tuning window around the selected semitone centre
  always_comb begin
    ctr_sel_c = ctr_tab[k_q];
    tol_c     = ctr_sel_c >> 7;
    hi_lim_c  = {1'b0, ctr_sel_c} + {1'b0, tol_c};
    lo_lim_c  = ctr_sel_c - tol_c;
  end

  // Next state: octave normalisation, linear boundary search, result and timeout update
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    k_d     = k_q;
    note_d  = note_q;
    flat_d  = flat_q;
    sharp_d = sharp_q;
    valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (load_c) begin
          p_d     = load_p_c;
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        // fold P into (B_HI/2, B_HI]; a zero period cannot be folded and is classified as-is
        if (p_q > B_HI) begin
          p_d = p_q >> 1;
        end else if ((p_q <= B_HI_HALF) && (p_q != '0)) begin
          p_d = p_q << 1;
        end else begin
          k_d     = '0;
          state_d = ST_CLASS;
        end
      end
      ST_CLASS: begin
        if (p_q > bnd_tab[k_q]) begin
          state_d = ST_DONE;
        end else if (k_q == K_LAST_BND) begin
          k_d     = K_TOP;
          state_d = ST_DONE;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      ST_DONE: begin
        note_d  = NOTE_W'(k_q);
        flat_d  = {1'b0, p_q} > hi_lim_c;
        sharp_d = p_q < lo_lim_c;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (timeout_c && (state_q != ST_DONE)) begin
      note_d  = NOTE_NONE;
      flat_d  = 1'b0;
      sharp_d = 1'b0;
      valid_d = 1'b1;
    end
  end

  // FSM, datapath and output registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      k_q     <= '0;
      note_q  <= NOTE_NONE;
      flat_q  <= 1'b0;
      sharp_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      k_q     <= k_d;
      note_q  <= note_d;
      flat_q  <= flat_d;
      sharp_q <= sharp_d;
      valid_q <= valid_d;
    end
  end

  assign note_o  = note_q;
  assign flat_o  = flat_q;
  assign sharp_o = sharp_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_period_to_note.sv
// Directed bench for period_to_note, scaled to a 600 kHz clock so every scenario stays short.
module tb_period_to_note;

  localparam int unsigned CLK_HZ      = 600_000;
  localparam int unsigned PERIOD_W    = 20;
  localparam int unsigned TIMEOUT_CYC = 10_000;
  localparam int unsigned MIN_PERIOD  = 50;
  localparam int unsigned LAT_MAX     = PERIOD_W + 14;
  localparam int unsigned N_CASES     = 8;

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic       edge_in = 1'b0;
  logic [3:0] note;
  logic       flat;
  logic       sharp;
  logic       valid;

  int n_checks    = 0;
  int n_fail      = 0;
  int valid_total = 0;
  int base;

  // period, edges, note, flat, sharp (periods at 600 kHz: 440, 220, 261.63, 450, 431.7 Hz, G, G#, G# an octave up)
  int c_period [N_CASES] = '{1364, 2727, 2293, 1333, 1390, 765, 722, 361};
  int c_edges  [N_CASES] = '{4, 3, 3, 3, 3, 3, 3, 3};
  int c_note   [N_CASES] = '{0, 0, 3, 0, 0, 10, 11, 11};
  int c_flat   [N_CASES] = '{0, 0, 0, 0, 1, 0, 0, 0};
  int c_sharp  [N_CASES] = '{0, 0, 0, 1, 0, 0, 0, 0};

  period_to_note #(
    .CLK_HZ      (CLK_HZ),
    .PERIOD_W    (PERIOD_W),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .MIN_PERIOD  (MIN_PERIOD)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .edge_i  (edge_in),
    .note_o  (note),
    .flat_o  (flat),
    .sharp_o (sharp),
    .valid_o (valid)
  );

  always #5 clk = ~clk;

  // Count every cycle in which valid_o is high
  always @(negedge clk) begin
    if (valid) valid_total <= valid_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse();
    edge_in = 1'b1;
    @(negedge clk);
    edge_in = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
  endtask

  task automatic tone(input int period, input int n);
    for (int i = 0; i < n; i++) begin
      pulse();
      if (i != n - 1) idle(period - 1);
    end
  endtask

  initial begin
    idle(3);
    check("rst_note", 32'(note), 32'hF);
    check("rst_flat", 32'(flat), 32'h0);
    check("rst_sharp", 32'(sharp), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    reset = 1'b0;

    for (int c = 0; c < N_CASES; c++) begin
      do_reset();
      idle(100);
      base = valid_total;
      tone(c_period[c], c_edges[c]);
      idle(LAT_MAX + 1);
      check($sformatf("p%0d_count", c_period[c]), 32'(valid_total - base), 32'(c_edges[c] - 1));
      check($sformatf("p%0d_note", c_period[c]), 32'(note), 32'(c_note[c]));
      check($sformatf("p%0d_flat", c_period[c]), 32'(flat), 32'(c_flat[c]));
      check($sformatf("p%0d_sharp", c_period[c]), 32'(sharp), 32'(c_sharp[c]));
    end

    // Timeout after a sharp tone, then recovery needing two edges
    do_reset();
    idle(100);
    tone(1333, 3);
    idle(LAT_MAX + 1);
    check("to_pre_sharp", 32'(sharp), 32'h1);
    base = valid_total;
    idle(TIMEOUT_CYC);
    check("to_count", 32'(valid_total - base), 32'd1);
    check("to_note", 32'(note), 32'hF);
    check("to_flat", 32'(flat), 32'h0);
    check("to_sharp", 32'(sharp), 32'h0);
    idle(2000);
    check("to_single", 32'(valid_total - base), 32'd1);
    base = valid_total;
    pulse();
    idle(LAT_MAX + 1);
    check("to_first_edge", 32'(valid_total - base), 32'd0);
    idle(1364 - LAT_MAX - 2);
    pulse();
    idle(LAT_MAX + 1);
    check("to_recover_cnt", 32'(valid_total - base), 32'd1);
    check("to_recover_note", 32'(note), 32'h0);

    // Glitch 25 cycles after an accepted edge must neither restart nor capture
    do_reset();
    idle(100);
    base = valid_total;
    pulse();
    idle(1363);
    pulse();
    idle(24);
    pulse();
    idle(1338);
    pulse();
    idle(LAT_MAX + 1);
    check("gl_count", 32'(valid_total - base), 32'd2);
    check("gl_note", 32'(note), 32'h0);
    check("gl_flat", 32'(flat), 32'h0);
    check("gl_sharp", 32'(sharp), 32'h0);

    // Reset while in NORM abandons the result
    do_reset();
    idle(100);
    base = valid_total;
    pulse();
    idle(2726);
    pulse();
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(LAT_MAX + 1);
    check("rn_count", 32'(valid_total - base), 32'd0);
    check("rn_note", 32'(note), 32'hF);
    idle(100);
    base = valid_total;
    tone(1364, 2);
    idle(LAT_MAX + 1);
    check("rn_after_cnt", 32'(valid_total - base), 32'd1);
    check("rn_after_note", 32'(note), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
